mips_data_mem_unit: RTL and testbench
=====================================

Name: mips_data_mem_unit

Overview:
Multi-cycle data-memory stage directly downstream of the 32-bit ALU in the MIPS core. It takes the ALU result as the byte address and register read data 2 as store data, and performs byte, halfword and word loads and stores with a configurable wait-state latency. It returns load data for the MemtoReg write-back mux. It raises a stall to freeze the program counter while an access is in flight.

Parameters:
ADDR_W, 8, word-index width; memory holds 2^ADDR_W 32-bit words.
LATENCY, 2, clock edges from request acceptance to completion; legal range 1..15.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
req_valid  input  1  access request from the core.
mem_read  input  1  load request (control signal MemRead).
mem_write  input  1  store request (control signal MemWrite).
size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
sign_ext  input  1  loads only: 1 sign-extends byte/half, 0 zero-extends.
addr  input  32  byte address (ALU result).
write_data  input  32  store data; byte/half taken from the low bits.
read_data  output  32  load result, registered.
ready  output  1  one-cycle completion pulse.
err  output  1  one-cycle error pulse, coincident with ready.
stall  output  1  high while an access is in flight (state BUSY).

Behaviour:
- States: IDLE, BUSY, DONE. Reset forces IDLE, cnt=0, read_data=0, ready=0, err=0, stall=0. Memory contents are not reset.
- Acceptance: a request is accepted on an edge where req_valid=1 and the state is IDLE or DONE. In every other state req_valid is ignored.
- Legality checks, applied at acceptance:
  - Exactly one of mem_read/mem_write must be 1.
  - size must not be 11.
  - Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
  - Both mem_read and mem_write 0 while req_valid=1: treated as a no-op error.
- Illegal request: go to DONE on the acceptance edge, no memory access, read_data unchanged. ready=1 and err=1 in the following cycle.
- Legal request:
  - On the acceptance edge, latch addr, write_data, size, sign_ext and op; set cnt=LATENCY-1; go to BUSY.
  - In BUSY: if cnt≠0, decrement cnt. If cnt=0, perform the access and go to DONE.
  - Net effect: ready is high in the cycle after edge T0+LATENCY, where T0 is the acceptance edge.
- DONE lasts one cycle. With no new request it returns to IDLE. A new request accepted in DONE gives back-to-back operation.
- stall = (state==BUSY), decoded from registered state. ready and err are high only in DONE.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
- Byte order is big-endian: byte offset 0 maps to word bits [31:24], offset 3 to [7:0]. Half offset 0 maps to [31:16], offset 2 to [15:0].
- Store: only the addressed byte lanes are written, all on the completing edge; other lanes are preserved.
- Load: the selected byte or half is right-justified, then sign- or zero-extended to 32 bits. It is registered into read_data on the completing edge and held until the next successful load.
- Stores and errors leave read_data unchanged.
- Reset mid-operation: the access is aborted and a pending store is not written. State returns to IDLE; no ready pulse.
- Reset has priority over a simultaneous req_valid.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10 and load word from 0x10 (LATENCY=2) -> stall high 2 cycles per access; ready one cycle after edge T0+2; read_data=0xDEADBEEF; err=0.
- Store byte 0x7F at 0x11 over 0xDEADBEEF, then load word 0x10 -> 0xDE7FBEEF. Load byte 0x13 with sign_ext=1 -> 0xFFFFFFEF; with sign_ext=0 -> 0x000000EF.
- Load half from 0x12 with sign_ext=1 over 0xDE7FBEEF -> 0xFFFFBEEF. Load half from 0x11 -> err=1 and ready=1 the cycle after acceptance, no stall, read_data unchanged.
- req_valid held high continuously with alternating store/load -> each new request accepted in the DONE cycle, stall deasserted only during DONE, and no request lost or duplicated.
- Store word 0x12345678 at 0x20, with reset asserted during BUSY -> outputs return to 0 and no ready pulse; a later load of 0x20 returns the prior contents.
- ADDR_W=8: store word 0xCAFEF00D to 0x400, then load 0x000 -> 0xCAFEF00D (wrap). mem_read=mem_write=1 -> err=1.

Source files
------------

// File: rtl/mips_data_mem_unit.sv
// Multi-cycle data-memory stage: big-endian byte/half/word loads and stores
// with a fixed wait-state latency, a stall while busy and a done/error pulse.
module mips_data_mem_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err,
  output logic        stall
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BA_W  = ADDR_W + 2;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [BA_W-1:0]      r_addr;
  logic [31:0]          r_wdata;
  logic [1:0]           r_size;
  logic                 r_sext;
  logic                 r_write;
  logic [31:0]          r_read_data;
  logic                 r_ready;
  logic                 r_err;
  logic                 r_stall;
  logic [31:0]          r_mem [DEPTH];

  logic                 w_accept;
  logic                 w_aligned;
  logic                 w_legal;
  logic                 w_complete;
  logic [ADDR_W-1:0]    w_word_idx;
  logic [1:0]           w_off;
  logic [4:0]           w_bsh;
  logic [4:0]           w_hsh;
  logic [31:0]          w_mem_word;
  logic [31:0]          w_store_word;
  logic [31:0]          w_load_val;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic                 w_unused_addr;

  // Address bits above the memory span are deliberately ignored (wrap-around).
  assign w_unused_addr = ^addr[31:BA_W];

  // Request legality and acceptance.
  always_comb begin
    w_aligned = 1'b1;
    if (size == SZ_HALF) w_aligned = ~addr[0];
    if (size == SZ_WORD) w_aligned = (addr[1:0] == 2'b00);
    w_legal    = (mem_read ^ mem_write) && (size != 2'b11) && w_aligned;
    w_accept   = req_valid && (r_state != S_BUSY);
    w_complete = (r_state == S_BUSY) && (r_cnt == '0);
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_legal ? S_BUSY : S_DONE;
      S_BUSY:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  if (w_accept) w_next = w_legal ? S_BUSY : S_DONE;
               else          w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane selection: big-endian, so offset 0 is the most significant lane.
  always_comb begin
    w_word_idx   = r_addr[BA_W-1:2];
    w_off        = r_addr[1:0];
    w_bsh        = {~w_off, 3'b000};
    w_hsh        = {~w_off[1], 4'b0000};
    w_mem_word   = r_mem[w_word_idx];
    w_byte       = w_mem_word[w_bsh +: 8];
    w_half       = w_mem_word[w_hsh +: 16];
    w_store_word = w_mem_word;
    w_load_val   = w_mem_word;
    case (r_size)
      SZ_BYTE: begin
        w_store_word[w_bsh +: 8] = r_wdata[7:0];
        w_load_val = {{24{r_sext & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        w_store_word[w_hsh +: 16] = r_wdata[15:0];
        w_load_val = {{16{r_sext & w_half[15]}}, w_half};
      end
      default: begin
        w_store_word = r_wdata;
        w_load_val   = w_mem_word;
      end
    endcase
  end

  // Control state, wait-state counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_read_data <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_DONE);
      r_err   <= w_accept && !w_legal;
      r_stall <= (w_next == S_BUSY);
      if (w_accept && w_legal) begin
        r_cnt <= CNT_W'(LATENCY - 1);
      end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_complete && !r_write) r_read_data <= w_load_val;
    end
  end

  // Request capture at acceptance; no reset needed on the datapath.
  always_ff @(posedge clock) begin
    if (!reset && w_accept && w_legal) begin
      r_addr  <= addr[BA_W-1:0];
      r_wdata <= write_data;
      r_size  <= size;
      r_sext  <= sign_ext;
      r_write <= mem_write;
    end
  end

  // Storage array; a store lands only on a completing edge outside reset.
  always_ff @(posedge clock) begin
    if (!reset && w_complete && r_write) r_mem[w_word_idx] <= w_store_word;
  end

  assign read_data = r_read_data;
  assign ready     = r_ready;
  assign err       = r_err;
  assign stall     = r_stall;

endmodule

// File: tb/tb_mips_data_mem_unit.sv
// Bench for mips_data_mem_unit: byte-array reference model, directed steps
// followed by randomized back-to-back traffic.
module tb_mips_data_mem_unit;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned MEMB    = 4 << ADDR_W;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        err;
  logic        stall;

  logic [7:0]  model_mem [MEMB];
  logic [31:0] model_rd;
  int          checks = 0;
  int          failures = 0;

  mips_data_mem_unit #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .size       (size),
    .sign_ext   (sign_ext),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .err        (err),
    .stall      (stall)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input bit rd, input bit wr, input logic [1:0] sz,
                                  input logic [31:0] a);
    if (rd == wr) return 1'b0;
    if (sz == 2'd3) return 1'b0;
    if (sz == 2'd1 && a[0] != 1'b0) return 1'b0;
    if (sz == 2'd2 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sx,
                                             input logic [31:0] a);
    int unsigned b = a % MEMB;
    logic [7:0]  v8;
    logic [15:0] v16;
    if (sz == 2'd0) begin
      v8 = model_mem[b];
      return sx ? {{24{v8[7]}}, v8} : {24'h0, v8};
    end
    if (sz == 2'd1) begin
      v16 = {model_mem[b], model_mem[b+1]};
      return sx ? {{16{v16[15]}}, v16} : {16'h0, v16};
    end
    return {model_mem[b], model_mem[b+1], model_mem[b+2], model_mem[b+3]};
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int unsigned b = a % MEMB;
    if (sz == 2'd0) model_mem[b] = d[7:0];
    else if (sz == 2'd1) begin
      model_mem[b]   = d[15:8];
      model_mem[b+1] = d[7:0];
    end else begin
      for (int i = 0; i < 4; i++) model_mem[b+i] = d[31-8*i -: 8];
    end
  endtask

  // Issue one request (state must be IDLE or DONE) and check its whole timeline.
  task automatic req(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                     input logic [31:0] a, input logic [31:0] d, input bit hold);
    mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
    addr = a; write_data = d; req_valid = 1'b1;
    tick();
    if (!hold) req_valid = 1'b0;
    if (!is_legal(rd, wr, sz, a)) begin
      chk("ill_ready", 32'(ready), 32'd1);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_stall", 32'(stall), 32'd0);
      chk("ill_rdata", read_data, model_rd);
    end else begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        chk("busy_stall", 32'(stall), 32'd1);
        chk("busy_ready", 32'(ready), 32'd0);
        tick();
      end
      chk("done_ready", 32'(ready), 32'd1);
      chk("done_err", 32'(err), 32'd0);
      chk("done_stall", 32'(stall), 32'd0);
      if (rd) model_rd = model_load(sz, sx, a);
      else    model_store(sz, a, d);
      chk("rdata", read_data, model_rd);
    end
  endtask

  task automatic go_idle();
    req_valid = 1'b0;
    tick();
    chk("idle_ready", 32'(ready), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    int          sel;
    bit          rd;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] a;

    // Reset state
    model_rd = '0;
    tick();
    tick();
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    tick();

    // Fill all words back-to-back so the model knows every byte.
    for (int w = 0; w < (1 << ADDR_W); w++) req(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b1);
    go_idle();

    // Directed steps
    req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("lw_10", read_data, 32'hDEADBEEF);
    req(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000007F, 1'b0);
    req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("lw_merge", read_data, 32'hDE7FBEEF);
    req(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
    chk("lb_sx", read_data, 32'hFFFFFFEF);
    req(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
    chk("lbu", read_data, 32'h000000EF);
    req(1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
    chk("lh_sx", read_data, 32'hFFFFBEEF);
    req(1'b1, 1'b0, 2'd1, 1'b1, 32'h11, 32'h0, 1'b0);
    chk("lh_misaligned_hold", read_data, 32'hFFFFBEEF);
    go_idle();

    // Reset on the completing edge of a store aborts it.
    mem_read = 1'b0; mem_write = 1'b1; size = 2'd2; sign_ext = 1'b0;
    addr = 32'h20; write_data = 32'h12345678; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < int'(LATENCY) - 1; i++) tick();
    chk("abort_busy", 32'(stall), 32'd1);
    reset = 1'b1;
    tick();
    model_rd = '0;
    chk("abort_rdata", read_data, 32'h0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    go_idle();
    req(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);

    // Address wrap and both-strobes error
    req(1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, 1'b0);
    req(1'b1, 1'b0, 2'd2, 1'b0, 32'h000, 32'h0, 1'b0);
    chk("wrap", read_data, 32'hCAFEF00D);
    req(1'b1, 1'b1, 2'd2, 1'b0, 32'h000, 32'h0, 1'b0);
    req(1'b0, 1'b0, 2'd2, 1'b0, 32'h000, 32'h0, 1'b0);
    req(1'b1, 1'b0, 2'd3, 1'b0, 32'h000, 32'h0, 1'b0);
    go_idle();

    // Randomized traffic, mostly back-to-back
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 15));
      if (sel == 0)      begin rd = 1'b0; wr = 1'b0; end
      else if (sel == 1) begin rd = 1'b1; wr = 1'b1; end
      else               begin rd = sel[0]; wr = !sel[0]; end
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      req(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 9) == 0) go_idle();
    end
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
